// File: rtl/doorlock_pkg.sv
// Shared types and constants for the door lock sequencer: state encodings,
// key codes and a digit classifier.
package doorlock_pkg;

  // Low two bits of each encoding are the externally visible state code.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_ENT  = 3'b001,
    ST_OPEN = 3'b011,
    ST_SET  = 3'b010,
    ST_LOCK = 3'b100
  } state_e;

  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;

  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'd9);
  endfunction

endpackage

// File: rtl/doorlock_ctrl_digit_buffer.sv
// Entry buffer: shifts digits in at the LSB end (first digit ends up in the
// MSBs) and keeps a count that saturates at N; extra digits are dropped.
module digit_buffer #(
  parameter int unsigned N  = 6,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            push_i,
  input  logic [3:0]      digit_i,
  output logic [4*N-1:0]  data_o,
  output logic [CW-1:0]   cnt_o,
  output logic            full_o
);

  localparam int unsigned DW = 4 * N;

  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign full_o = (cnt_q == CW'(N));
  assign data_o = data_q;
  assign cnt_o  = cnt_q;

  // Clear wins over push; a push into a full buffer is discarded.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (push_i && !full_o) begin
      data_d = DW'({data_q, digit_i});
      cnt_d  = cnt_q + CW'(1);
    end else begin
      data_d = data_q;
      cnt_d  = cnt_q;
    end
  end

  // Buffer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/doorlock_ctrl.sv
// Door lock sequencer: keypad-driven code entry, unlock window, code change,
// inactivity timeout and lockout after repeated failures.
module doorlock_ctrl
  import doorlock_pkg::*;
#(
  parameter int unsigned             CODE_LEN       = 6,
  parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE   = 24'h123456,
  parameter int unsigned             OPEN_CYCLES    = 8,
  parameter int unsigned             TIMEOUT_CYCLES = 32,
  parameter int unsigned             MAX_FAIL       = 3,
  parameter int unsigned             LOCK_CYCLES    = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_valid_i,
  input  logic [3:0] key_i,
  output logic [1:0] state_o,
  output logic       unlock_o,
  output logic       alarm_o,
  output logic [1:0] fail_cnt_o,
  output logic [2:0] digit_cnt_o
);

  localparam int unsigned CW   = $clog2(CODE_LEN + 1);
  localparam int unsigned TMAX = (TIMEOUT_CYCLES > OPEN_CYCLES)
                               ? ((TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES)
                               : ((OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES);
  localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [1:0]    FAIL_MAX  = 2'(MAX_FAIL);

  state_e                state_q, state_d;
  logic [1:0]            fail_q, fail_d;
  logic [4*CODE_LEN-1:0] code_q, code_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  unlock_q, unlock_d;
  logic                  alarm_q, alarm_d;

  logic                  buf_clr_s, buf_push_s, buf_full_s;
  logic [4*CODE_LEN-1:0] buf_data_s;
  logic [CW-1:0]         buf_cnt_s;

  logic key_dig_s, key_a_s, key_b_s, expired_s;
  logic [1:0] fail_inc_s;

  assign key_dig_s  = key_valid_i && is_digit(key_i);
  assign key_a_s    = key_valid_i && (key_i == KEY_A);
  assign key_b_s    = key_valid_i && (key_i == KEY_B);
  assign expired_s  = (tmr_q == '0);
  assign fail_inc_s = fail_q + 2'd1;

  digit_buffer #(.N(CODE_LEN), .CW(CW)) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (buf_clr_s),
    .push_i  (buf_push_s),
    .digit_i (key_i),
    .data_o  (buf_data_s),
    .cnt_o   (buf_cnt_s),
    .full_o  (buf_full_s)
  );

  // Next-state logic; timer expiry is evaluated before any key.
  always_comb begin
    state_d    = state_q;
    fail_d     = fail_q;
    code_d     = code_q;
    buf_clr_s  = 1'b0;
    buf_push_s = 1'b0;
    if (tmr_q != '0) begin
      tmr_d = tmr_q - TW'(1);
    end else begin
      tmr_d = tmr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (key_dig_s) begin
          buf_push_s = 1'b1;
          state_d    = ST_ENT;
          tmr_d      = TO_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ENT: begin
        if (expired_s) begin
          buf_clr_s = 1'b1;
          state_d   = ST_IDLE;
        end else if (key_dig_s) begin
          buf_push_s = 1'b1;
          tmr_d      = TO_LOAD;
        end else if (key_a_s) begin
          buf_clr_s = 1'b1;
          if (buf_full_s && (buf_data_s == code_q)) begin
            fail_d  = 2'd0;
            state_d = ST_OPEN;
            tmr_d   = OPEN_LOAD;
          end else if (fail_inc_s == FAIL_MAX) begin
            fail_d  = fail_inc_s;
            state_d = ST_LOCK;
            tmr_d   = LOCK_LOAD;
          end else begin
            fail_d  = fail_inc_s;
            state_d = ST_IDLE;
          end
        end else if (key_b_s) begin
          buf_clr_s = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_ENT;
        end
      end

      ST_SET: begin
        if (expired_s) begin
          buf_clr_s = 1'b1;
          state_d   = ST_IDLE;
        end else if (key_dig_s) begin
          buf_push_s = 1'b1;
          tmr_d      = TO_LOAD;
        end else if (key_a_s || key_b_s) begin
          buf_clr_s = 1'b1;
          state_d   = ST_IDLE;
          if (key_a_s && buf_full_s) begin
            code_d = buf_data_s;
          end else begin
            code_d = code_q;
          end
        end else begin
          state_d = ST_SET;
        end
      end

      ST_OPEN: begin
        if (expired_s) begin
          state_d = ST_IDLE;
        end else if (key_b_s) begin
          state_d = ST_SET;
          tmr_d   = TO_LOAD;
        end else begin
          state_d = ST_OPEN;
        end
      end

      ST_LOCK: begin
        if (expired_s) begin
          fail_d  = 2'd0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCK;
        end
      end

      default: begin
        buf_clr_s = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase

    unlock_d = (state_d == ST_OPEN);
    alarm_d  = (state_d == ST_LOCK);
  end

  // State, stored code, timer and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      fail_q   <= 2'd0;
      code_q   <= DEFAULT_CODE;
      tmr_q    <= '0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fail_q   <= fail_d;
      code_q   <= code_d;
      tmr_q    <= tmr_d;
      unlock_q <= unlock_d;
      alarm_q  <= alarm_d;
    end
  end

  assign state_o     = state_q[1:0];
  assign unlock_o    = unlock_q;
  assign alarm_o     = alarm_q;
  assign fail_cnt_o  = fail_q;
  assign digit_cnt_o = 3'(buf_cnt_s);

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Bench for doorlock_ctrl: directed keypad sequences, a per-cycle reference
// model compare, and literal spot checks of the expected behaviour.
module tb_doorlock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'h0;
  logic [1:0] state_o;
  logic       unlock_o, alarm_o;
  logic [1:0] fail_cnt_o;
  logic [2:0] digit_cnt_o;

  int checks = 0;
  int errors = 0;

  doorlock_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .key_valid_i (key_valid),
    .key_i       (key),
    .state_o     (state_o),
    .unlock_o    (unlock_o),
    .alarm_o     (alarm_o),
    .fail_cnt_o  (fail_cnt_o),
    .digit_cnt_o (digit_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 entry, 2 open, 3 set, 4 lockout.
  int m_st;
  int m_buf[$];
  int m_code[6];
  int m_fail;
  int m_el;

  task automatic m_go(input int s);
    m_st = s;
    m_el = 0;
  endtask

  task automatic model_tick(input logic r);
    bit dig, ka, kb, expd, same;
    int lim;
    if (r) begin
      m_st = 0; m_buf.delete(); m_code = '{1, 2, 3, 4, 5, 6}; m_fail = 0; m_el = 0;
      return;
    end
    dig  = key_valid && (key <= 4'd9);
    ka   = key_valid && (key == 4'hA);
    kb   = key_valid && (key == 4'hB);
    lim  = (m_st == 2) ? 8 : (m_st == 4) ? 16 : 32;
    expd = (m_st != 0) && (m_el + 1 >= lim);
    m_el = m_el + 1;
    case (m_st)
      0: if (dig) begin m_buf.delete(); m_buf.push_back(int'(key)); m_go(1); end
      1, 3: begin
        if (expd) begin
          m_buf.delete(); m_go(0);
        end else if (dig) begin
          if (m_buf.size() < 6) m_buf.push_back(int'(key));
          m_el = 0;
        end else if (ka) begin
          if (m_st == 1) begin
            same = (m_buf.size() == 6);
            if (same) for (int i = 0; i < 6; i++) if (m_buf[i] != m_code[i]) same = 1'b0;
            if (same) begin m_fail = 0; m_go(2); end
            else begin m_fail = m_fail + 1; m_go((m_fail == 3) ? 4 : 0); end
          end else begin
            if (m_buf.size() == 6) for (int i = 0; i < 6; i++) m_code[i] = m_buf[i];
            m_go(0);
          end
          m_buf.delete();
        end else if (kb) begin
          m_buf.delete(); m_go(0);
        end
      end
      2: if (expd) m_go(0); else if (kb) m_go(3);
      4: if (expd) begin m_fail = 0; m_go(0); end
      default: m_go(0);
    endcase
  endtask

  always @(posedge clk or posedge rst) model_tick(rst);

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_state",  int'(state_o),
          (m_st == 1) ? 1 : (m_st == 2) ? 3 : (m_st == 3) ? 2 : 0);
      chk("m_unlock", int'(unlock_o), (m_st == 2) ? 1 : 0);
      chk("m_alarm",  int'(alarm_o),  (m_st == 4) ? 1 : 0);
      chk("m_fail",   int'(fail_cnt_o), m_fail);
      chk("m_dcnt",   int'(digit_cnt_o), m_buf.size());
    end
  end

  // Each key occupies exactly one cycle; called from a falling edge.
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key = k;
    @(negedge clk);
    key_valid = 1'b0;
    key = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enter(input logic [23:0] code);
    logic [23:0] c;
    c = code;
    for (int i = 5; i >= 0; i--) press(c[4*i +: 4]);
    press(4'hA);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("rst_state", int'(state_o), 0);
    chk("rst_unlock", int'(unlock_o), 0);
    chk("rst_dcnt", int'(digit_cnt_o), 0);

    // Correct code opens for exactly 8 cycles
    press(4'h1);
    chk("ent_state", int'(state_o), 1);
    chk("ent_dcnt", int'(digit_cnt_o), 1);
    for (int d = 2; d <= 6; d++) press(4'(d));
    press(4'hA);
    chk("open_state", int'(state_o), 3);
    chk("open_unlock", int'(unlock_o), 1);
    idle(7);
    chk("open_last", int'(unlock_o), 1);
    idle(1);
    chk("open_done", int'(state_o), 0);
    chk("open_done_u", int'(unlock_o), 0);

    // Three failures -> lockout that ignores keys
    press(4'h1); press(4'h2); press(4'h3); press(4'hA);
    chk("fail1", int'(fail_cnt_o), 1);
    enter(24'h999999);
    chk("fail2", int'(fail_cnt_o), 2);
    enter(24'h123457);
    chk("fail3", int'(fail_cnt_o), 3);
    chk("lock_alarm", int'(alarm_o), 1);
    chk("lock_state", int'(state_o), 0);
    enter(24'h123456);
    idle(8);
    chk("lock_still", int'(alarm_o), 1);
    idle(1);
    chk("lock_end_alarm", int'(alarm_o), 0);
    chk("lock_end_fail", int'(fail_cnt_o), 0);

    // Change code to 654321 via B during OPEN
    enter(24'h123456);
    press(4'hB);
    chk("set_state", int'(state_o), 2);
    chk("set_unlock", int'(unlock_o), 0);
    enter(24'h654321);
    chk("set_done", int'(state_o), 0);
    enter(24'h123456);
    chk("old_code_fail", int'(fail_cnt_o), 1);
    enter(24'h654321);
    chk("new_code_open", int'(state_o), 3);
    idle(8);

    // Cancel keeps fail count; extra digit dropped
    press(4'h1); press(4'hA);
    press(4'h1); press(4'h2); press(4'hB);
    chk("cancel_state", int'(state_o), 0);
    chk("cancel_fail", int'(fail_cnt_o), 1);
    press(4'h6); press(4'h5); press(4'h4); press(4'h3); press(4'h2); press(4'h1); press(4'h7);
    chk("sat_dcnt", int'(digit_cnt_o), 6);
    press(4'hA);
    chk("overflow_open", int'(state_o), 3);
    idle(8);

    // Entry timeout, and a short code in SET
    press(4'h4);
    idle(31);
    chk("to_before", int'(state_o), 1);
    idle(1);
    chk("to_state", int'(state_o), 0);
    chk("to_dcnt", int'(digit_cnt_o), 0);
    enter(24'h654321);
    press(4'hB);
    press(4'h1); press(4'h2); press(4'h3); press(4'hA);
    chk("short_set", int'(state_o), 0);
    enter(24'h654321);
    chk("code_kept", int'(state_o), 3);
    idle(8);

    // Async reset mid-OPEN restores default code
    enter(24'h654321);
    idle(2);
    #2 rst = 1'b1;
    #1 chk("async_unlock", int'(unlock_o), 0);
    chk("async_state", int'(state_o), 0);
    idle(2);
    rst = 1'b0;
    enter(24'h123456);
    chk("default_back", int'(state_o), 3);
    idle(9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
